// File: rtl/zion_sft_pkg.sv
// Shared definitions for the shift arbiter slice: op encodings, output-register
// state and the shift-amount width helper.
package zion_sft_pkg;

  // {left, right, arith} op encodings
  localparam logic [2:0] SFT_SLL = 3'b100;
  localparam logic [2:0] SFT_SRL = 3'b010;
  localparam logic [2:0] SFT_SRA = 3'b011;

  // Occupancy of the one-entry output register
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } sft_state_e;

  // Shift-amount width: 5 bits for XLEN=32, 6 bits for XLEN=64
  function automatic int unsigned sft_sw(input int unsigned rv64);
    return 5 + ((rv64 != 0) ? 1 : 0);
  endfunction

endpackage

// File: rtl/zion_sft_core.sv
// Combinational shift executor with op legality check. Illegal ops give a
// zero result and raise err.
module zion_sft_core import zion_sft_pkg::*; #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned SW   = 5
) (
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] s1,
  input  logic [SW-1:0]   s2,
  output logic [XLEN-1:0] rslt,
  output logic            err
);

  // Decode op and shift by the full SW-bit amount
  always_comb begin
    rslt = '0;
    err  = 1'b0;
    case (op)
      SFT_SLL: rslt = s1 << s2;
      SFT_SRL: rslt = s1 >> s2;
      SFT_SRA: rslt = $signed(s1) >>> s2;
      default: err  = 1'b1;
    endcase
  end

endmodule

// File: rtl/zion_sft_arb.sv
// Two-requester round-robin arbiter in front of a shared shift executor with a
// one-entry registered output. Optional per-requester grant counters are
// enabled with the ZION_SFT_ARB_STAT_EN macro.
module zion_sft_arb import zion_sft_pkg::*; #(
  parameter  int unsigned RV64 = 0,
  localparam int unsigned XLEN = (RV64 != 0) ? 64 : 32,
  localparam int unsigned SW   = sft_sw(RV64)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_vld,
  output logic [1:0]        req_rdy,
  input  logic [5:0]        req_op,
  input  logic [2*XLEN-1:0] req_s1,
  input  logic [2*SW-1:0]   req_s2,
  output logic              rsp_vld,
  input  logic              rsp_rdy,
  output logic [XLEN-1:0]   rsp_rslt,
  output logic              rsp_id,
  output logic              rsp_err
`ifdef ZION_SFT_ARB_STAT_EN
  ,
  output logic [31:0]       gnt_cnt0,
  output logic [31:0]       gnt_cnt1
`endif
);

  sft_state_e      state_q, state_d;
  logic            last_gnt_q;
  logic [XLEN-1:0] rslt_q;
  logic            id_q;
  logic            err_q;

  logic            accept;
  logic            gnt_id;
  logic            hs;
  logic [2:0]      sel_op;
  logic [XLEN-1:0] sel_s1;
  logic [SW-1:0]   sel_s2;
  logic [XLEN-1:0] core_rslt;
  logic            core_err;

  // Accept check, round-robin pick and one-hot ready; ready is held low in reset
  always_comb begin
    accept = (state_q == EMPTY) || rsp_rdy;
    case (req_vld)
      2'b10:   gnt_id = 1'b1;
      2'b11:   gnt_id = ~last_gnt_q;
      default: gnt_id = 1'b0;
    endcase
    hs      = accept && (|req_vld) && rst_n;
    req_rdy = '0;
    if (hs) req_rdy[gnt_id] = 1'b1;
  end

  // Route the granted requester's operands to the shared executor
  always_comb begin
    sel_op = gnt_id ? req_op[5:3]           : req_op[2:0];
    sel_s1 = gnt_id ? req_s1[2*XLEN-1:XLEN] : req_s1[XLEN-1:0];
    sel_s2 = gnt_id ? req_s2[2*SW-1:SW]     : req_s2[SW-1:0];
  end

  zion_sft_core #(
    .XLEN (XLEN),
    .SW   (SW)
  ) u_core (
    .op   (sel_op),
    .s1   (sel_s1),
    .s2   (sel_s2),
    .rslt (core_rslt),
    .err  (core_err)
  );

  // Output-register occupancy: fill on handshake, empty on drain without refill
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (hs) state_d = FULL;
      FULL:  if (rsp_rdy && !hs) state_d = EMPTY;
    endcase
  end

  // State, round-robin pointer and result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      last_gnt_q <= 1'b1;
      rslt_q     <= '0;
      id_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (hs) begin
        last_gnt_q <= gnt_id;
        rslt_q     <= core_rslt;
        id_q       <= gnt_id;
        err_q      <= core_err;
      end
    end
  end

  // rsp_vld comes straight from the register, so rsp_rdy never reaches it
  assign rsp_vld  = (state_q == FULL);
  assign rsp_rslt = rslt_q;
  assign rsp_id   = id_q;
  assign rsp_err  = err_q;

`ifdef ZION_SFT_ARB_STAT_EN
  logic [31:0] cnt0_q, cnt1_q;

  // Per-requester accepted-request counters, wrapping at 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else if (hs) begin
      if (gnt_id) cnt1_q <= cnt1_q + 32'd1;
      else        cnt0_q <= cnt0_q + 32'd1;
    end
  end

  assign gnt_cnt0 = cnt0_q;
  assign gnt_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_zion_sft_arb.sv
// Bench for zion_sft_arb: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural model.
module tb_zion_sft_arb;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_vld;
  logic [1:0]  req_rdy;
  logic [5:0]  req_op;
  logic [63:0] req_s1;
  logic [9:0]  req_s2;
  logic        rsp_vld;
  logic        rsp_rdy;
  logic [31:0] rsp_rslt;
  logic        rsp_id;
  logic        rsp_err;

  logic [1:0]   r64_vld;
  logic [1:0]   r64_rdy;
  logic [5:0]   r64_op;
  logic [127:0] r64_s1;
  logic [11:0]  r64_s2;
  logic         r64_rsp_vld;
  logic [63:0]  r64_rslt;
  logic         r64_id;
  logic         r64_err;

`ifdef ZION_SFT_ARB_STAT_EN
  logic [31:0] gnt_cnt0, gnt_cnt1, r64_cnt0, r64_cnt1;
`endif

  int errors = 0;
  int checks = 0;

  zion_sft_arb #(.RV64(0)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_vld  (req_vld),
    .req_rdy  (req_rdy),
    .req_op   (req_op),
    .req_s1   (req_s1),
    .req_s2   (req_s2),
    .rsp_vld  (rsp_vld),
    .rsp_rdy  (rsp_rdy),
    .rsp_rslt (rsp_rslt),
    .rsp_id   (rsp_id),
    .rsp_err  (rsp_err)
`ifdef ZION_SFT_ARB_STAT_EN
    ,
    .gnt_cnt0 (gnt_cnt0),
    .gnt_cnt1 (gnt_cnt1)
`endif
  );

  zion_sft_arb #(.RV64(1)) dut64 (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_vld  (r64_vld),
    .req_rdy  (r64_rdy),
    .req_op   (r64_op),
    .req_s1   (r64_s1),
    .req_s2   (r64_s2),
    .rsp_vld  (r64_rsp_vld),
    .rsp_rdy  (1'b1),
    .rsp_rslt (r64_rslt),
    .rsp_id   (r64_id),
    .rsp_err  (r64_err)
`ifdef ZION_SFT_ARB_STAT_EN
    ,
    .gnt_cnt0 (r64_cnt0),
    .gnt_cnt1 (r64_cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [2:0] op, input logic [31:0] s1,
                         input logic [4:0] s2);
    req_op[i*3 +: 3] = op;
    req_s1[i*32 +: 32] = s1;
    req_s2[i*5 +: 5] = s2;
  endtask

  // Reference shift computed by integer arithmetic on 32-bit operands
  function automatic logic [31:0] ref_rslt(input logic [2:0] op, input logic [31:0] s1,
                                           input int unsigned sh);
    longint p, v, q;
    p = 1;
    for (int k = 0; k < int'(sh); k++) p = p * 2;
    v = longint'(s1);
    case (op)
      3'b100:  q = (v * p) % 64'sd4294967296;
      3'b010:  q = v / p;
      3'b011: begin
        if (s1[31]) v = v - 64'sd4294967296;
        q = (v >= 0) ? v / p : -((-v + p - 1) / p);
      end
      default: q = 0;
    endcase
    return q[31:0];
  endfunction

  function automatic bit ref_err(input logic [2:0] op);
    return !(op == 3'b100 || op == 3'b010 || op == 3'b011);
  endfunction

  // Behavioural model: one output slot, round-robin pointer, grant counters
  bit          m_full;
  logic [31:0] m_rslt;
  bit          m_id;
  bit          m_err;
  bit          m_last;
  logic [31:0] m_cnt [2];

  initial begin : model
    bit          gv;
    int          g;
    logic [1:0]  exp_rdy;
    logic [2:0]  op;
    logic [31:0] s1;
    int unsigned sh;
    m_full = 0; m_rslt = '0; m_id = 0; m_err = 0; m_last = 1;
    m_cnt[0] = '0; m_cnt[1] = '0;
    forever begin
      @(negedge clk);
      gv = 0;
      g  = 0;
      if (!rst_n) begin
        chk("rst_req_rdy", req_rdy, 2'b00);
        chk("rst_rsp_vld", rsp_vld, 1'b0);
      end else begin
        if (req_vld == 2'b11) g = m_last ? 0 : 1;
        else if (req_vld == 2'b10) g = 1;
        gv = (!m_full || rsp_rdy) && (req_vld != 2'b00);
        exp_rdy = gv ? 2'(1 << g) : 2'b00;
        chk("mdl_req_rdy", req_rdy, exp_rdy);
        chk("mdl_rsp_vld", rsp_vld, m_full);
        if (m_full) begin
          chk("mdl_rsp_rslt", rsp_rslt, m_rslt);
          chk("mdl_rsp_id", rsp_id, m_id);
          chk("mdl_rsp_err", rsp_err, m_err);
        end
`ifdef ZION_SFT_ARB_STAT_EN
        chk("mdl_gnt_cnt0", gnt_cnt0, m_cnt[0]);
        chk("mdl_gnt_cnt1", gnt_cnt1, m_cnt[1]);
`endif
      end
      op = req_op[g*3 +: 3];
      s1 = req_s1[g*32 +: 32];
      sh = int'(req_s2[g*5 +: 5]);
      @(posedge clk);
      if (!rst_n) begin
        m_full = 0; m_rslt = '0; m_id = 0; m_err = 0; m_last = 1;
        m_cnt[0] = '0; m_cnt[1] = '0;
      end else if (gv) begin
        m_full = 1;
        m_rslt = ref_rslt(op, s1, sh);
        m_err  = ref_err(op);
        m_id   = (g == 1);
        m_last = (g == 1);
        m_cnt[g] = m_cnt[g] + 32'd1;
      end else if (m_full && rsp_rdy) begin
        m_full = 0;
      end
    end
  end

  logic [2:0] legal_ops [3];

  initial begin : stim
    legal_ops[0] = 3'b100; legal_ops[1] = 3'b010; legal_ops[2] = 3'b011;
    rst_n = 1'b0; req_vld = 2'b11; req_op = '0; req_s1 = '0; req_s2 = '0; rsp_rdy = 1'b1;
    r64_vld = 2'b00; r64_op = '0; r64_s1 = '0; r64_s2 = '0;
    #3;
    chk("reset_req_rdy", req_rdy, 2'b00);
    chk("reset_rsp_vld", rsp_vld, 1'b0);
    chk("reset_rsp_rslt", rsp_rslt, 32'h0);
    chk("reset_rsp_id", rsp_id, 1'b0);
    chk("reset_rsp_err", rsp_err, 1'b0);
    step();
    step();
    rst_n = 1'b1;

    // Conflict after reset: grants 0,1,0,1; plus a 64-bit SRL on the wide instance
    set_req(0, 3'b100, 32'h3, 5'd1);
    set_req(1, 3'b011, 32'h8000_0000, 5'd4);
    req_vld = 2'b11;
    r64_vld = 2'b01; r64_op = 6'b000_010;
    r64_s1 = {64'h0, 64'h8000_0000_0000_0000}; r64_s2 = {6'd0, 6'd63};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("conflict_gnt", req_rdy, (k % 2 == 0) ? 2'b01 : 2'b10);
      if (k > 0) begin
        chk("conflict_id", rsp_id, (k % 2 == 0) ? 1'b1 : 1'b0);
        chk("conflict_rslt", rsp_rslt, (k % 2 == 0) ? 32'hF800_0000 : 32'h6);
      end
      if (k == 0) chk("rv64_req_rdy", r64_rdy, 2'b01);
      if (k == 1) begin
        chk("rv64_rsp_vld", r64_rsp_vld, 1'b1);
        chk("rv64_rslt", r64_rslt, 64'h1);
`ifdef ZION_SFT_ARB_STAT_EN
        chk("rv64_gnt_cnt0", r64_cnt0, 32'd1);
`endif
      end
      step();
      r64_vld = 2'b00;
    end

    // Single SLL by 31
    req_vld = 2'b01;
    set_req(0, 3'b100, 32'h1, 5'd31);
    @(negedge clk);
    chk("sll_req_rdy", req_rdy, 2'b01);
    chk("conflict_last_rslt", rsp_rslt, 32'hF800_0000);
    step();
    req_vld = 2'b00;
    @(negedge clk);
    chk("sll_rsp_vld", rsp_vld, 1'b1);
    chk("sll_rslt", rsp_rslt, 32'h8000_0000);
    chk("sll_id", rsp_id, 1'b0);
    chk("sll_err", rsp_err, 1'b0);

    // Backpressure for three cycles, then drain and refill in one cycle
    step();
    req_vld = 2'b01;
    set_req(0, 3'b100, 32'h5, 5'd2);
    @(negedge clk);
    chk("bp_first_rdy", req_rdy, 2'b01);
    step();
    rsp_rdy = 1'b0;
    set_req(0, 3'b100, 32'h7, 5'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_stall_rdy", req_rdy, 2'b00);
      chk("bp_stall_vld", rsp_vld, 1'b1);
      chk("bp_stall_rslt", rsp_rslt, 32'd20);
      step();
    end
    rsp_rdy = 1'b1;
    @(negedge clk);
    chk("bp_refill_rdy", req_rdy, 2'b01);
    step();
    req_vld = 2'b00;
    @(negedge clk);
    chk("bp_next_vld", rsp_vld, 1'b1);
    chk("bp_next_rslt", rsp_rslt, 32'd7);

    // Illegal op is accepted and flagged
    step();
    req_vld = 2'b01;
    set_req(0, 3'b110, 32'hFFFF_FFFF, 5'd3);
    @(negedge clk);
    chk("illegal_rdy", req_rdy, 2'b01);
    step();
    req_vld = 2'b00;
    @(negedge clk);
    chk("illegal_rslt", rsp_rslt, 32'h0);
    chk("illegal_err", rsp_err, 1'b1);

    // Reset asserted mid-stall clears outputs without a clock edge
    step();
    req_vld = 2'b01;
    set_req(0, 3'b100, 32'h9, 5'd0);
    step();
    req_vld = 2'b00;
    rsp_rdy = 1'b0;
    @(negedge clk);
    chk("rst_full_vld", rsp_vld, 1'b1);
    chk("rst_full_rslt", rsp_rslt, 32'h9);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_vld", rsp_vld, 1'b0);
    chk("async_rst_rslt", rsp_rslt, 32'h0);
    step();
    step();
    rst_n = 1'b1;
    rsp_rdy = 1'b1;
    req_vld = 2'b11;
    set_req(0, 3'b100, 32'h1, 5'd1);
    set_req(1, 3'b100, 32'h1, 5'd2);
    @(negedge clk);
    chk("post_rst_gnt", req_rdy, 2'b01);
    step();
    req_vld = 2'b00;
    @(negedge clk);
    chk("post_rst_id", rsp_id, 1'b0);
    chk("post_rst_rslt", rsp_rslt, 32'h2);

    // Randomized traffic, checked by the model every cycle
    for (int n = 0; n < 3000; n++) begin
      step();
      req_vld = 2'($urandom_range(0, 3));
      rsp_rdy = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(0, 7) < 7) req_op[i*3 +: 3] = legal_ops[$urandom_range(0, 2)];
        else req_op[i*3 +: 3] = 3'($urandom_range(0, 7));
        req_s1[i*32 +: 32] = $urandom;
        req_s2[i*5 +: 5] = 5'($urandom_range(0, 31));
      end
    end
    step();
    req_vld = 2'b00;
    rsp_rdy = 1'b1;
    step();
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/zion_sft_arb.md
ZION_SFT_ARB -- requirements
Module: zion_sft_arb

Interface
REQ-001 Parameter RV64, default 0, selects the data width: 0 gives XLEN=32, 1 gives XLEN=64.
REQ-002 Parameter SW is derived as 5+RV64 and is the width of the shift-amount field.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req_vld  input  2  request valid for requester i, where i is 0 or 1.
REQ-006 req_rdy  output  2  request accepted by the arbiter.
REQ-007 req_op  input  2x3  {left,right,arith} per requester; legal values are 100 (SLL), 010 (SRL) and 011 (SRA).
REQ-008 req_s1  input  2xXLEN  operand per requester.
REQ-009 req_s2  input  2xSW  shift amount per requester.
REQ-010 rsp_vld  output  1  result valid.
REQ-011 rsp_rdy  input  1  consumer ready.
REQ-012 rsp_rslt  output  XLEN  shift result.
REQ-013 rsp_id  output  1  index of the requester that owns the result.
REQ-014 rsp_err  output  1  the owning request carried an illegal op.

Function
REQ-015 The block SHALL contain one shared shift executor and a one-entry output register, with states EMPTY and FULL.
REQ-016 Accept condition: accept = EMPTY, or (FULL and rsp_vld and rsp_rdy).
- A grant is issued only when accept is true.
- req_rdy[i] is 1 only for the granted requester, and only in that cycle.
REQ-017 Arbitration is round-robin.
- If only one requester is valid, that requester is granted.
- If both are valid, the requester other than last_gnt is granted.
- last_gnt updates only on a completed request handshake.
REQ-018 On a request handshake the result SHALL be computed combinationally and registered, so rsp_vld goes high on the next cycle (latency 1).
- Results for a back-to-back stream: one per cycle when rsp_rdy is held at 1.
REQ-019 Operation results:
- SLL: s1<<s2.
- SRL: logical s1>>s2.
- SRA: arithmetic right shift, sign-filled from s1[XLEN-1].
- s2 uses all SW bits; no truncation is applied.
REQ-020 An illegal op SHALL still be accepted, and produces rsp_rslt=0 with rsp_err=1.
REQ-021 While FULL and rsp_rdy=0, rsp_rslt, rsp_id and rsp_err SHALL hold stable, req_rdy SHALL be 0, and last_gnt SHALL be unchanged.
REQ-022 A simultaneous drain and accept SHALL replace the entry, and the state stays FULL.
REQ-023 A drain with no new request SHALL move the state FULL->EMPTY.
REQ-024 State transitions:
- EMPTY->FULL on accept.
- FULL->FULL on drain+accept, or on stall.
- FULL->EMPTY on drain only.
REQ-025 No combinational path SHALL exist from rsp_rdy to rsp_vld.
- The path from rsp_rdy to req_rdy is permitted.

Reset
REQ-026 Asserting rst_n low at any time, including while FULL, SHALL asynchronously clear all of the following:
- state to EMPTY;
- rsp_vld, rsp_rslt, rsp_id and rsp_err to 0;
- last_gnt to 1, so that requester 0 wins the first conflict.
REQ-027 req_rdy SHALL be 0 while reset is asserted.
- An in-flight result is discarded by reset and is not replayed.

Configuration
REQ-028 Macro ZION_SFT_ARB_STAT_EN:
- When defined, the block adds the outputs gnt_cnt0 and gnt_cnt1 (32-bit each). These count accepted requests per requester, wrap at 2^32, and reset to 0.
- When undefined, these ports and counters are absent and all other behaviour is identical.

Structure
REQ-029 A shared package zion_sft_pkg SHALL hold:
- the op encodings SFT_SLL=3'b100, SFT_SRL=3'b010 and SFT_SRA=3'b011;
- a state enum with EMPTY and FULL;
- the function deriving SW from RV64.
REQ-030 A combinational sub-module zion_sft_core SHALL perform the shift and the legality check; the arbiter and register logic live in zion_sft_arb.

Verification
REQ-031 Single shift: RV64=0, req_vld=01, op=100, s1=0x0000_0001, s2=31, rsp_rdy=1.
- Required: req_rdy=01 that cycle.
- Next cycle: rsp_vld=1, rslt=0x8000_0000, id=0, err=0.
REQ-032 Arithmetic shift and conflict: both requesters valid every cycle, with req1 op=011, s1=0x8000_0000, s2=4.
- Required: the first grant goes to requester 0, then grants alternate 0,1,0,1.
- Requester 1 results are 0xF800_0000.
REQ-033 Backpressure: rsp_rdy=0 for 3 cycles while FULL with req0 valid.
- Required: req_rdy=00 and outputs stable during the stall.
- When rsp_rdy rises: a drain and a new accept in the same cycle, and the next result appears the following cycle.
REQ-034 Illegal op: op=110, s1=0xFFFF_FFFF.
- Required: accepted; next cycle rslt=0, err=1.
REQ-035 Reset while FULL: deassert rst_n mid-stall.
- Required: rsp_vld=0 immediately without waiting for a clock edge.
- After release, requester 0 wins the first conflict.
REQ-036 RV64=1, op=010, s1=0x8000_0000_0000_0000, s2=63.
- Required: rslt=1.
- With ZION_SFT_ARB_STAT_EN defined: gnt_cnt0=1.
